// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: access-size codes and
// helpers for byte strobes, load lane extraction/extension and alignment.
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } f3_e;

    // Write strobe for one word, one bit per byte lane,
    // shifted to the addressed lane.
    function automatic logic [7:0] byte_mask(
        input logic [2:0] f3,
        input logic [2:0] lane,
        input int         w
    );
        logic [7:0] m;
        case (f3)
            F3_B, F3_BU: m = 8'h01;
            F3_H, F3_HU: m = 8'h03;
            F3_W, F3_WU: m = 8'h0F;
            default:     m = 8'hFF;
        endcase
        m = m << lane;
        if (w == 32) m[7:4] = '0;
        return m;
    endfunction

    // Pick the addressed lanes out of a word and sign/zero extend.
    function automatic logic [63:0] load_extend(
        input logic [63:0] word,
        input logic [2:0]  f3,
        input logic [2:0]  lane,
        input int          w
    );
        logic [63:0] s;
        logic [63:0] r;
        s = word >> {lane, 3'b000};
        case (f3)
            F3_B:    r = {{56{s[7]}}, s[7:0]};
            F3_H:    r = {{48{s[15]}}, s[15:0]};
            F3_W:    r = {{32{s[31]}}, s[31:0]};
            F3_D:    r = s;
            F3_BU:   r = {56'd0, s[7:0]};
            F3_HU:   r = {48'd0, s[15:0]};
            F3_WU:   r = {32'd0, s[31:0]};
            default: r = '0;
        endcase
        if (w == 32) r[63:32] = '0;
        return r;
    endfunction

    // Natural alignment check; code 111 is treated as doubleword
    // but is rejected as illegal elsewhere anyway.
    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [2:0] addr
    );
        logic m;
        case (f3)
            F3_H, F3_HU: m = addr[0];
            F3_W, F3_WU: m = |addr[1:0];
            F3_B, F3_BU: m = 1'b0;
            default:     m = |addr;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// LAT-deep shift register carrying {valid, fault, data} for load responses.
// Ports: clk, rst (sync, active high), in_* request side, out_* response side.
module dmem_rd_pipe #(
    parameter int LAT = 1,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_fault,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic          out_fault,
    output logic [DW-1:0] out_data
);

    logic [DW+1:0] sr [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= {in_valid, in_fault, in_data};
            for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
    end

    assign {out_valid, out_fault, out_data} = sr[LAT-1];

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with RISC-V sized loads/stores and a
// configurable-latency load pipeline.
// Ports: clk, rst, address, MemWrite, MemRead, funct3, write_data in;
//        read_data, read_valid, fault out.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int W      = 32,
    parameter int N      = 5,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] address,
    input  logic         MemWrite,
    input  logic         MemRead,
    input  logic [2:0]   funct3,
    input  logic [W-1:0] write_data,
    output logic [W-1:0] read_data,
    output logic         read_valid,
    output logic         fault
);

    localparam int NB    = W / 8;
    localparam int LB    = $clog2(NB);
    localparam int DEPTH = (2 ** N) / NB;
    localparam int IW    = N - LB;
    localparam bit IS32  = (W == 32);

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] widx;
    logic [2:0]    lane;
    logic          f3_ill;
    logic          mis;
    logic          st_bad;
    logic          ld_bad;
    logic [NB-1:0] be;
    logic [W-1:0]  wdata_sh;
    logic [W-1:0]  ld_val;
    logic          st_fault_q;
    logic          p_fault;
    logic          unused_addr;

    assign widx = address[N-1:LB];
    assign lane = 3'(address[LB-1:0]);
    assign unused_addr = ^address[W-1:N];

    assign f3_ill = (funct3 == 3'b111)
                  | (IS32 & (funct3 == F3_D))
                  | (IS32 & (funct3 == F3_WU));
    assign mis = is_misaligned(funct3, address[2:0]);

    // Stores only accept the signed-size codes.
    assign st_bad = f3_ill | funct3[2] | mis;
    // A rejected store in the same cycle poisons the load too.
    assign ld_bad = f3_ill | mis | (MemWrite & st_bad);

    assign be       = NB'(byte_mask(funct3, lane, W));
    assign wdata_sh = write_data << {lane, 3'b000};
    assign ld_val   = W'(load_extend(64'(mem[widx]), funct3, lane, W));

    // Read is sampled before the write lands: read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            st_fault_q <= 1'b0;
        end else begin
            if (MemWrite && !st_bad) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
            st_fault_q <= MemWrite & ~MemRead & st_bad;
        end
    end

    dmem_rd_pipe #(
        .LAT (RD_LAT),
        .DW  (W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (MemRead),
        .in_fault  (MemRead & ld_bad),
        .in_data   ((MemRead && !ld_bad) ? ld_val : '0),
        .out_valid (read_valid),
        .out_fault (p_fault),
        .out_data  (read_data)
    );

    assign fault = p_fault | st_fault_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomised and directed bench for data_memory_sized, W=32 and W=64
// instances driven in lockstep and compared to a byte-array model.
module tb_data_memory_sized;

    localparam int LAT32 = 3;
    localparam int LAT64 = 2;
    localparam int MAXE  = 4096;

    logic        clk;
    logic        rst;
    logic [63:0] address;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [63:0] write_data;

    logic [31:0] rd32;
    logic        rv32;
    logic        f32;
    logic [63:0] rd64;
    logic        rv64;
    logic        f64;

    int checks;
    int errors;
    int e;

    byte unsigned mem_m [2][32];
    bit          exp_v [2][MAXE];
    bit          exp_f [2][MAXE];
    bit   [63:0] exp_d [2][MAXE];

    data_memory_sized #(.W(32), .N(5), .RD_LAT(LAT32)) u32 (
        .clk        (clk),
        .rst        (rst),
        .address    (address[31:0]),
        .MemWrite   (mem_write),
        .MemRead    (mem_read),
        .funct3     (funct3),
        .write_data (write_data[31:0]),
        .read_data  (rd32),
        .read_valid (rv32),
        .fault      (f32)
    );

    data_memory_sized #(.W(64), .N(5), .RD_LAT(LAT64)) u64 (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .MemWrite   (mem_write),
        .MemRead    (mem_read),
        .funct3     (funct3),
        .write_data (write_data),
        .read_data  (rd64),
        .read_valid (rv64),
        .fault      (f64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: sim time exceeded, got hang expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h",
                     tag, e, got, exp);
        end
    endtask

    // Behaviour of one memory for a request taken at edge k.
    task automatic model(input int d, input int w, input int lat,
                         input int k, input bit r, input bit we,
                         input bit re, input bit [2:0] f3,
                         input bit [63:0] a, input bit [63:0] wd);
        int ad;
        int nb;
        int bits;
        bit ill;
        bit mis;
        bit stf;
        bit ldf;
        bit [63:0] val;
        if (r) begin
            for (int i = 0; i < 32; i++) mem_m[d][i] = 8'h00;
            for (int j = k; j < MAXE; j++) begin
                exp_v[d][j] = 1'b0;
                exp_f[d][j] = 1'b0;
                exp_d[d][j] = '0;
            end
            return;
        end
        ad   = int'(a[4:0]);
        nb   = 1 << f3[1:0];
        bits = 8 * nb;
        ill  = (f3 == 3'd7) || (w == 32 && (f3 == 3'd3 || f3 == 3'd6));
        mis  = (ad % nb) != 0;
        stf  = ill || f3[2] || mis;
        ldf  = ill || mis || (we && stf);
        if (re) begin
            val = '0;
            if (!ldf) begin
                for (int i = 0; i < nb; i++)
                    val |= 64'(mem_m[d][ad+i]) << (8 * i);
                if (!f3[2] && bits < w && val[bits-1])
                    val |= ~((64'd1 << bits) - 64'd1);
                if (w == 32) val &= 64'h0000_0000_FFFF_FFFF;
            end
            exp_v[d][k+lat-1] = 1'b1;
            exp_d[d][k+lat-1] = val;
            exp_f[d][k+lat-1] |= ldf;
        end
        if (we) begin
            if (!stf) begin
                for (int i = 0; i < nb; i++)
                    mem_m[d][ad+i] = wd[8*i +: 8];
            end else if (!re) begin
                exp_f[d][k] = 1'b1;
            end
        end
    endtask

    // One clock: check outputs of the last edge, apply the next request.
    task automatic step(input bit r, input bit we, input bit re,
                        input bit [2:0] f3, input bit [63:0] a,
                        input bit [63:0] wd);
        if (e > 0) begin
            check("valid32", 64'(rv32), 64'(exp_v[0][e]));
            check("data32",  64'(rd32), exp_d[0][e]);
            check("fault32", 64'(f32),  64'(exp_f[0][e]));
            check("valid64", 64'(rv64), 64'(exp_v[1][e]));
            check("data64",  rd64,      exp_d[1][e]);
            check("fault64", 64'(f64),  64'(exp_f[1][e]));
        end
        rst        = r;
        mem_write  = we;
        mem_read   = re;
        funct3     = f3;
        address    = a;
        write_data = wd;
        model(0, 32, LAT32, e + 1, r, we, re, f3, a, wd);
        model(1, 64, LAT64, e + 1, r, we, re, f3, a, wd);
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 64'd0, 64'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        e          = 0;
        rst        = 1'b1;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        funct3     = 3'd0;
        address    = '0;
        write_data = '0;

        step(1, 0, 0, 3'd0, 64'd0, 64'd0);
        step(1, 1, 1, 3'd2, 64'd4, 64'h1234_5678);
        idle(2);

        step(0, 1, 0, 3'd2, 64'h4, 64'hDEAD_BEEF);
        step(0, 0, 1, 3'd2, 64'h4, 64'd0);
        idle(4);

        step(0, 1, 0, 3'd0, 64'h9, 64'h80);
        step(0, 0, 1, 3'd0, 64'h9, 64'd0);
        step(0, 0, 1, 3'd4, 64'h9, 64'd0);
        step(0, 0, 1, 3'd2, 64'h8, 64'd0);
        idle(4);

        step(0, 0, 1, 3'd1, 64'h3, 64'd0);
        step(0, 1, 0, 3'd2, 64'h6, 64'hFFFF_FFFF);
        step(0, 0, 1, 3'd2, 64'h4, 64'd0);
        step(0, 0, 1, 3'd7, 64'h0, 64'd0);
        step(0, 1, 0, 3'd4, 64'h0, 64'h55);
        idle(4);

        step(0, 1, 0, 3'd2, 64'h10, 64'h1111_1111);
        step(0, 1, 1, 3'd2, 64'h10, 64'h2222_2222);
        step(0, 0, 1, 3'd2, 64'h10, 64'd0);
        idle(4);

        step(0, 1, 0, 3'd2, 64'h24, 64'hCAFE_F00D);
        step(0, 0, 1, 3'd2, 64'h4, 64'd0);
        step(0, 0, 1, 3'd2, 64'h24, 64'd0);
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, 3'd2, 64'(4 * i), 64'd0);
        idle(4);

        step(0, 0, 1, 3'd2, 64'h0, 64'd0);
        step(0, 0, 1, 3'd2, 64'h4, 64'd0);
        step(1, 0, 0, 3'd0, 64'h0, 64'd0);
        idle(4);
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, 3'd2, 64'(4 * i), 64'd0);
        idle(4);

        step(0, 1, 0, 3'd3, 64'h8, 64'h0123_4567_89AB_CDEF);
        step(0, 0, 1, 3'd3, 64'h8, 64'd0);
        step(0, 0, 1, 3'd6, 64'h8, 64'd0);
        step(0, 0, 1, 3'd3, 64'h4, 64'd0);
        idle(4);

        for (int i = 0; i < 900; i++) begin
            bit [63:0] a;
            bit [63:0] wd;
            bit [2:0]  f3;
            a  = 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            wd = {$urandom, $urandom};
            f3 = 3'($urandom_range(0, 7));
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 0,
                 f3, a, wd);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
Byte-addressed, word-organised data memory for the single-cycle/pipelined core. It supports RISC-V sized loads and stores selected by funct3: byte, halfword, word, and doubleword when W=64. Loads are sign- or zero-extended. Read latency is configurable through a pipeline with a valid strobe. Misaligned or illegal accesses are flagged instead of silently corrupting memory.

Parameters:
W, 32, data word width in bits; legal values 32 or 64.
N, 5, byte-address bits used; capacity 2^N bytes; depth DEPTH = 2^N/(W/8) words.
RD_LAT, 1, load latency in cycles from request edge to read_valid; legal range 1..4.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
address  in  W  byte address; only bits [N-1:0] used, upper bits ignored (wrap modulo 2^N).
MemWrite  in  1  store request this cycle.
MemRead  in  1  load request this cycle.
funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD (W=64 only), 100 LBU, 101 LHU, 110 LWU (W=64 only).
write_data  in  W  store data; the low 8/16/32/64 bits are used per size.
read_data  out  W  extended load result; valid when read_valid=1, otherwise 0.
read_valid  out  1  one-cycle pulse, RD_LAT cycles after an accepted MemRead.
fault  out  1  one-cycle pulse on misaligned or illegal access, aligned with that access's response timing.

Behaviour:
- Reset (rst=1 at posedge): all DEPTH words cleared to 0; pipeline flushed; read_data=0, read_valid=0, fault=0 on the following cycle. A request present during the reset cycle is dropped.
- Reset mid-operation: in-flight loads are discarded; no read_valid is issued for them.
- Word index = address[N-1:log2(W/8)]. Byte lane = address[log2(W/8)-1:0].
- Alignment rules:
  - Halfword requires address[0]=0.
  - Word requires address[1:0]=0.
  - Doubleword requires address[2:0]=0.
  - Byte accesses are always aligned.
- Illegal funct3:
  - 111 always.
  - 011 and 110 when W=32.
  - For stores, any funct3 other than 000/001/010/011.
- Store: on posedge with MemWrite=1 and a legal, aligned access, write only the addressed byte lanes (byte-enable mask). Other bytes of the word are unchanged.
- Faulted store: memory is untouched and fault pulses on the next cycle.
- Load: the addressed word is sampled at the request posedge. Lanes are selected, then sign-extended (000/001/010) or zero-extended (100/101/110).
- Load timing: the result enters an RD_LAT-stage shift pipeline (data, valid, fault). read_valid=1 exactly RD_LAT cycles after the request edge. Back-to-back loads every cycle are supported, giving one result per cycle.
- Faulted load: read_valid still pulses at the normal time, with read_data=0 and fault=1 in the same cycle.
- Simultaneous MemRead and MemWrite:
  - Both are performed using the single address and funct3.
  - The load returns the pre-write contents (read-before-write).
  - A store fault also marks the load as faulted.
  - fault follows the load timing when MemRead=1; otherwise it pulses one cycle after the store edge.
- A load issued in the cycle after a store to the same address returns the new data; there is no hazard.
- Idle cycles (neither request): no state change; outputs return to 0 once the pipeline drains.

Decomposition:
- Package dmem_pkg holds:
  - Access-size enum: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - Function byte_mask(funct3, lane, W) returning the write strobe.
  - Function load_extend(word, funct3, lane, W).
  - Function is_misaligned(funct3, addr).
- Sub-module dmem_rd_pipe: a parametrised RD_LAT-deep shift register carrying {valid, fault, data}, with synchronous reset.

Test Plan:
- Reset, then SW 0xDEADBEEF at address 0x4. LW at 0x4 -> read_valid exactly RD_LAT cycles later, read_data=0xDEADBEEF, fault=0.
- SB 0x80 at 0x9, then LB 0x9 -> 0xFFFFFF80. LBU 0x9 -> 0x00000080. LW 0x8 -> only byte 1 changed, other bytes 0.
- LH at 0x3 and SW at 0x6 -> fault pulse. For the store, memory is unchanged, verified by a later LW 0x4 = 0xDEADBEEF. For the load, read_valid=1 with read_data=0.
- Same-cycle MemRead+MemWrite LW/SW 0x10 with old value 0x11111111 and new value 0x22222222 -> load returns 0x11111111. The next LW 0x10 returns 0x22222222.
- Address 0x24 with N=5 wraps to 0x04 -> access hits word 1. Then back-to-back LWs over 0x0..0x1C -> eight consecutive read_valid pulses in address order.
- Assert rst while two loads are in flight -> no read_valid afterwards. All words read back 0. With W=64, SD/LD at 0x8 round-trips 0x0123456789ABCDEF.
